// File: rtl/puf_eval_ctrl.sv
// rtl/puf_eval_ctrl.sv - challenge/response controller for the arbiter PUF array
//
// Accepts a challenge, fires NEVAL launches into the arbiter array, counts
// the ones seen on each response bit and returns a majority-voted response
// together with a per-bit stability mask.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   chal_valid/chal_ready     challenge handshake, chal is the challenge value
//   puf_s, puf_c              launch strobe and challenge driven to the array
//   puf_q                     raw arbiter outputs (asynchronous to clk)
//   resp_valid/resp_ready     result handshake, resp/stable are the result
//   busy                      high whenever the controller is not idle
module puf_eval_ctrl #(
    parameter int W      = 64,
    parameter int NEVAL  = 5,
    parameter int SETTLE = 6,
    parameter int RELAX  = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         chal_valid,
    output logic         chal_ready,
    input  logic [W-1:0] chal,
    output logic         puf_s,
    output logic [W-1:0] puf_c,
    input  logic [W-1:0] puf_q,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [W-1:0] resp,
    output logic [W-1:0] stable,
    output logic         busy
);

    localparam int CW   = $clog2(NEVAL + 1);
    localparam int MAXT = (SETTLE > RELAX) ? SETTLE : RELAX;
    localparam int TW   = $clog2(MAXT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RELAX,
        S_LAUNCH,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   tmr;
    logic [TW-1:0]   tmr_nxt;
    logic [CW-1:0]   eval_cnt;
    logic [W-1:0]    q_s1;
    logic [W-1:0]    q_sync;
    logic [CW-1:0]   cnt     [W];
    logic [CW-1:0]   cnt_inc [W];
    logic [W-1:0]    resp_nxt;
    logic [W-1:0]    stable_nxt;
    logic            accept;
    logic            last_eval;

    // Per-bit tally including the sample being taken this cycle, so the
    // voted result can be registered on the same edge that enters DONE.
    always_comb begin
        resp_nxt   = '0;
        stable_nxt = '0;
        for (int i = 0; i < W; i++) begin
            cnt_inc[i]    = cnt[i] + CW'(q_sync[i]);
            resp_nxt[i]   = (cnt_inc[i] > CW'(NEVAL / 2));
            stable_nxt[i] = (cnt_inc[i] == '0) || (cnt_inc[i] == CW'(NEVAL));
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        accept    = 1'b0;
        last_eval = (eval_cnt == CW'(NEVAL - 1));
        case (state)
            S_IDLE: begin
                if (chal_valid && chal_ready) begin
                    accept    = 1'b1;
                    state_nxt = S_RELAX;
                    tmr_nxt   = '0;
                end
            end
            S_RELAX: begin
                if (tmr == TW'(RELAX - 1)) begin
                    state_nxt = S_LAUNCH;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + TW'(1);
                end
            end
            S_LAUNCH: begin
                if (tmr == TW'(SETTLE - 1)) begin
                    state_nxt = S_SAMPLE;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + TW'(1);
                end
            end
            S_SAMPLE: begin
                tmr_nxt   = '0;
                state_nxt = last_eval ? S_DONE : S_RELAX;
            end
            S_DONE: begin
                if (resp_valid && resp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            tmr        <= '0;
            eval_cnt   <= '0;
            q_s1       <= '0;
            q_sync     <= '0;
            puf_s      <= 1'b0;
            puf_c      <= '0;
            chal_ready <= 1'b0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp       <= '0;
            stable     <= '0;
            for (int i = 0; i < W; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            q_s1       <= puf_q;
            q_sync     <= q_s1;
            state      <= state_nxt;
            tmr        <= tmr_nxt;
            // puf_s trails the LAUNCH state by one cycle: it rises in the
            // second LAUNCH cycle and is still high through SAMPLE, giving
            // SETTLE cycles of high time per launch.
            puf_s      <= (state == S_LAUNCH);
            chal_ready <= (state_nxt == S_IDLE);
            busy       <= (state_nxt != S_IDLE);
            resp_valid <= (state_nxt == S_DONE);
            if (accept) begin
                puf_c    <= chal;
                eval_cnt <= '0;
                for (int i = 0; i < W; i++) begin
                    cnt[i] <= '0;
                end
            end
            if (state == S_SAMPLE) begin
                eval_cnt <= eval_cnt + CW'(1);
                for (int i = 0; i < W; i++) begin
                    cnt[i] <= cnt_inc[i];
                end
                if (last_eval) begin
                    resp   <= resp_nxt;
                    stable <= stable_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb/tb_puf_eval_ctrl.sv - directed self-checking bench for puf_eval_ctrl
module tb_puf_eval_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        chal_valid = 1'b0;
    logic        chal_ready;
    logic [63:0] chal = '0;
    logic        puf_s;
    logic [63:0] puf_c;
    logic [63:0] puf_q = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp;
    logic [63:0] stable;
    logic        busy;

    localparam logic [63:0] MASK_A5  = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [63:0] ALL1     = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] C_A      = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] R_A      = 64'hA486_E0C2_2C0E_684A;
    localparam logic [63:0] C_B      = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] R_B      = 64'h5B79_1F3D_D3F1_97B5;
    localparam logic [63:0] C_C      = 64'h1111_2222_3333_4444;
    localparam logic [63:0] R_C      = 64'hB4B4_8787_9696_E1E1;
    localparam logic [63:0] C_D      = 64'h0F0F_0F0F_0F0F_0F0F;
    localparam logic [63:0] R_D      = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] S_NOISY  = 64'hFFFF_FFFF_FFFF_FFFC;

    puf_eval_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .chal_valid (chal_valid),
        .chal_ready (chal_ready),
        .chal       (chal),
        .puf_s      (puf_s),
        .puf_c      (puf_c),
        .puf_q      (puf_q),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp       (resp),
        .stable     (stable),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Arbiter array model: mode 0 ideal (q = c ^ A5..), mode 1 adds noise
    // on bits 0 and 1 depending on the launch index.
    int mode = 0;
    int launch_idx = 0;
    always @(posedge puf_s) begin
        logic [63:0] q;
        q = puf_c ^ MASK_A5;
        if (mode == 1) begin
            q[0] = (launch_idx == 1) || (launch_idx == 3);
            q[1] = (launch_idx % 2 == 0);
        end
        puf_q = q;
        launch_idx++;
    end

    int hi_len = 0;
    int n_pulse = 0;
    int bad_width = 0;
    always @(negedge clk) begin
        if (puf_s === 1'b1) begin
            hi_len++;
        end else if (hi_len != 0) begin
            n_pulse++;
            if (hi_len != 6) bad_width++;
            hi_len = 0;
        end
    end

    task automatic accept_chal(input logic [63:0] c, output int acc);
        int t;
        t = 0;
        @(negedge clk);
        while (chal_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("accept_ready", 64'(chal_ready), 64'd1);
        chal       = c;
        chal_valid = 1'b1;
        @(posedge clk);
        #1;
        acc        = cyc;
        chal_valid = 1'b0;
        launch_idx = 0;
        n_pulse    = 0;
        bad_width  = 0;
        hi_len     = 0;
    endtask

    task automatic wait_resp(input int acc, output int lat);
        int t;
        t = 0;
        @(negedge clk);
        while (resp_valid !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        lat = (resp_valid === 1'b1) ? (cyc - acc) : -1;
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        int lat;
        int viol;
        int seen;
        int t;
        int acc_k [4];
        logic [63:0] c_k [4];
        logic [63:0] r_k [4];

        // 1: reset
        rstn = 1'b0;
        @(negedge clk);
        check("rst_ctrl", 64'({chal_ready, puf_s, resp_valid, busy}), 64'd0);
        check("rst_puf_c", puf_c, 64'd0);
        check("rst_resp", resp, 64'd0);
        check("rst_stable", stable, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rel_chal_ready", 64'(chal_ready), 64'd1);
        check("rel_busy", 64'(busy), 64'd0);

        // 2: ideal PUF
        mode = 0;
        accept_chal(C_A, acc);
        check("t2_puf_c", puf_c, C_A);
        check("t2_busy", 64'(busy), 64'd1);
        check("t2_chal_ready", 64'(chal_ready), 64'd0);
        wait_resp(acc, lat);
        check("t2_latency", 64'(lat), 64'd55);
        check("t2_resp", resp, R_A);
        check("t2_stable", stable, ALL1);
        @(negedge clk);
        check("t2_pulses", 64'(n_pulse), 64'd5);
        check("t2_bad_width", 64'(bad_width), 64'd0);
        handshake();
        @(negedge clk);
        check("t2_valid_drop", 64'(resp_valid), 64'd0);
        check("t2_resp_hold", resp, R_A);
        check("t2_idle_ready", 64'(chal_ready), 64'd1);

        // 3: noisy bits 0 and 1
        mode = 1;
        accept_chal(C_A, acc);
        wait_resp(acc, lat);
        check("t3_latency", 64'(lat), 64'd55);
        check("t3_resp", resp, R_A);
        check("t3_stable", stable, S_NOISY);
        handshake();

        // 4: backpressure in DONE with a new challenge waiting
        mode = 0;
        accept_chal(C_B, acc);
        wait_resp(acc, lat);
        check("t4_latency", 64'(lat), 64'd55);
        check("t4_resp", resp, R_B);
        chal       = C_C;
        chal_valid = 1'b1;
        viol = 0;
        repeat (10) begin
            @(negedge clk);
            if (resp !== R_B || stable !== ALL1 || puf_c !== C_B ||
                chal_ready !== 1'b0 || puf_s !== 1'b0 || resp_valid !== 1'b1)
                viol++;
        end
        check("t4_hold_viol", 64'(viol), 64'd0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("t4_no_early_accept", puf_c, C_B);
        check("t4_ready_after_hs", 64'(chal_ready), 64'd1);
        @(posedge clk);
        #1;
        acc        = cyc;
        chal_valid = 1'b0;
        launch_idx = 0;
        check("t4_new_puf_c", puf_c, C_C);
        check("t4_new_busy", 64'(busy), 64'd1);
        wait_resp(acc, lat);
        check("t4_new_latency", 64'(lat), 64'd55);
        check("t4_new_resp", resp, R_C);
        handshake();

        // 5: reset during launch 2
        mode = 0;
        accept_chal(C_D, acc);
        t = 0;
        while (launch_idx < 3 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("t5_in_launch2", 64'(puf_s), 64'd1);
        rstn = 1'b0;
        @(negedge clk);
        check("t5_rst_puf_s", 64'(puf_s), 64'd0);
        check("t5_rst_ctrl", 64'({chal_ready, resp_valid, busy}), 64'd0);
        rstn = 1'b1;
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen++;
        end
        check("t5_no_valid", 64'(seen), 64'd0);
        mode = 1;
        accept_chal(C_A, acc);
        wait_resp(acc, lat);
        check("t5_fresh_latency", 64'(lat), 64'd55);
        check("t5_fresh_resp", resp, R_A);
        check("t5_fresh_stable", stable, S_NOISY);
        handshake();

        // 6: back-to-back with valid/ready held high
        mode = 0;
        c_k[0] = C_A; r_k[0] = R_A;
        c_k[1] = C_B; r_k[1] = R_B;
        c_k[2] = C_C; r_k[2] = R_C;
        c_k[3] = C_D; r_k[3] = R_D;
        resp_ready = 1'b1;
        chal_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            t = 0;
            @(negedge clk);
            while (chal_ready !== 1'b1 && t < 200) begin
                @(negedge clk);
                t++;
            end
            chal = c_k[k];
            @(posedge clk);
            #1;
            acc_k[k] = cyc;
            wait_resp(acc_k[k], lat);
            if (k == 3) chal_valid = 1'b0;
            check($sformatf("t6_latency_%0d", k), 64'(lat), 64'd55);
            check($sformatf("t6_resp_%0d", k), resp, r_k[k]);
            check($sformatf("t6_stable_%0d", k), stable, ALL1);
            if (k > 0)
                check($sformatf("t6_spacing_%0d", k), 64'(acc_k[k] - acc_k[k-1]), 64'd57);
        end
        @(negedge clk);
        resp_ready = 1'b0;
        @(negedge clk);
        check("t6_final_idle", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
